digit_entry_buffer: RTL and testbench

- Parametrised keypad-to-digit storage block; successor to the fixed 4/6-register keypad capture path.
- Takes raw keypad levels and priority-encodes them to a digit. Detects each discrete press and shifts the digit into a DEPTH-slot BCD buffer.
- Tracks fill level and supports backspace, sync clear, parallel load and a selectable overflow policy.
- Sits between the keypad inputs and the compare/display logic, on a single clock.

---
 rtl/digit_entry_pkg.sv | 20 ++
 rtl/key_press_detector.sv | 35 +++
 rtl/digit_entry_buffer.sv | 138 +++++++++++++
 tb/tb_digit_entry_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/digit_entry_pkg.sv
// Shared constants for the keypad digit entry buffer.
package digit_entry_pkg;

  localparam logic [1:0] MODE_LOCK  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam int unsigned OVF_DROP  = 0;
  localparam int unsigned OVF_SHIFT = 1;

  localparam logic [3:0] BLANK_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ShNone,
    ShIn,
    ShOut
  } shift_e;

endpackage

// File: rtl/key_press_detector.sv
// Priority-encodes keypad levels and emits a single-cycle event on each fresh press.
module key_press_detector
  import digit_entry_pkg::*;
#(
  parameter int unsigned KEYS    = 10,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEYS-1:0]    key_i,
  output logic               event_o,
  output logic [DIGIT_W-1:0] code_o
);

  logic any_q, any_d;

  always_comb begin
    any_d  = |key_i;
    code_o = '0;
    for (int i = 0; i < int'(KEYS); i++) begin
      if (key_i[i]) code_o = DIGIT_W'(i);
    end
    event_o = any_d & ~any_q;
  end

  // Resets high so a key held through reset never registers as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_q <= 1'b1;
    end else begin
      any_q <= any_d;
    end
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit storage: captures discrete presses into a DEPTH-slot BCD shift buffer.
module digit_entry_buffer
  import digit_entry_pkg::*;
#(
  parameter int unsigned         DEPTH      = 6,
  parameter int unsigned         DIGIT_W    = 4,
  parameter int unsigned         KEYS       = 10,
  parameter logic [DIGIT_W-1:0]  BLANK      = DIGIT_W'(BLANK_DEFAULT),
  parameter int unsigned         OVF_POLICY = OVF_DROP,
  localparam int unsigned        CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEYS-1:0]            key_in,
  input  logic [1:0]                 mode,
  input  logic [DEPTH*DIGIT_W-1:0]   load_in,
  input  logic                       clr,
  input  logic                       del,
  output logic [DEPTH*DIGIT_W-1:0]   digits_out,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic                       empty,
  output logic                       key_valid,
  output logic [DIGIT_W-1:0]         key_code,
  output logic                       overflow
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DIGIT_W-1:0] slot_q [DEPTH];
  logic [DIGIT_W-1:0] slot_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DIGIT_W-1:0] key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               overflow_q, overflow_d;

  logic               press;
  logic [DIGIT_W-1:0] press_code;
  shift_e             op;

  key_press_detector #(
    .KEYS    (KEYS),
    .DIGIT_W (DIGIT_W)
  ) u_key_press_detector (
    .clk     (clk),
    .rst     (rst),
    .key_i   (key_in),
    .event_o (press),
    .code_o  (press_code)
  );

  always_comb begin
    op          = ShNone;
    slot_d      = slot_q;
    count_d     = count_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    overflow_d  = 1'b0;

    if (clr) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = BLANK;
      count_d = '0;
    end else if (mode == MODE_LOAD) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = load_in[i*DIGIT_W +: DIGIT_W];
      count_d = FullCnt;
    end else if (mode != MODE_LOCK) begin
      // A press coinciding with del is dropped, not held over.
      if (del) begin
        if (count_q != '0) begin
          op      = ShOut;
          count_d = count_q - CNT_W'(1);
        end
      end else if (press) begin
        if (count_q == FullCnt) begin
          overflow_d = 1'b1;
          if (OVF_POLICY == OVF_SHIFT) begin
            op          = ShIn;
            key_valid_d = 1'b1;
            key_code_d  = press_code;
          end
        end else begin
          op          = ShIn;
          count_d     = count_q + CNT_W'(1);
          key_valid_d = 1'b1;
          key_code_d  = press_code;
        end
      end
    end

    // Left entry grows from slot 0 upward; right entry grows from the top slot downward.
    if (op == ShIn) begin
      if (mode == MODE_LEFT) begin
        slot_d[0] = press_code;
        for (int i = 1; i < int'(DEPTH); i++) slot_d[i] = slot_q[i-1];
      end else begin
        slot_d[DEPTH-1] = press_code;
        for (int i = 0; i < int'(DEPTH) - 1; i++) slot_d[i] = slot_q[i+1];
      end
    end else if (op == ShOut) begin
      if (mode == MODE_LEFT) begin
        slot_d[DEPTH-1] = BLANK;
        for (int i = 0; i < int'(DEPTH) - 1; i++) slot_d[i] = slot_q[i+1];
      end else begin
        slot_d[0] = BLANK;
        for (int i = 1; i < int'(DEPTH); i++) slot_d[i] = slot_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= BLANK;
      count_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    digits_out = '0;
    for (int i = 0; i < int'(DEPTH); i++) digits_out[i*DIGIT_W +: DIGIT_W] = slot_q[i];
  end

  assign count     = count_q;
  assign full      = (count_q == FullCnt);
  assign empty     = (count_q == '0);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: vector table plus hand sequences, one DUT per overflow policy.
module tb_digit_entry_buffer;

  logic        clk = 1'b0;
  logic        rst, clr, del;
  logic [1:0]  mode;
  logic [9:0]  key;
  logic [23:0] load;

  logic [23:0] d0_dig, d1_dig;
  logic [2:0]  d0_cnt, d1_cnt;
  logic        d0_full, d0_empty, d0_kv, d0_ovf;
  logic        d1_full, d1_empty, d1_kv, d1_ovf;
  logic [3:0]  d0_code, d1_code;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  digit_entry_buffer #(.OVF_POLICY(0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key), .mode(mode), .load_in(load), .clr(clr), .del(del),
    .digits_out(d0_dig), .count(d0_cnt), .full(d0_full), .empty(d0_empty),
    .key_valid(d0_kv), .key_code(d0_code), .overflow(d0_ovf)
  );

  digit_entry_buffer #(.OVF_POLICY(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key), .mode(mode), .load_in(load), .clr(clr), .del(del),
    .digits_out(d1_dig), .count(d1_cnt), .full(d1_full), .empty(d1_empty),
    .key_valid(d1_kv), .key_code(d1_code), .overflow(d1_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] m, input logic [9:0] k, input logic d, input logic c);
    mode = m;
    key  = k;
    del  = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every key_valid from dut0 must match the next queued digit.
  always @(negedge clk) begin : sb_mon
    logic [3:0] e;
    if (d0_kv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got key_valid with code %0h expected none", d0_code);
      end else begin
        e = exp_q.pop_front();
        chk("sb_code", {28'd0, d0_code}, {28'd0, e});
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [9:0]  key;
    logic        del;
    logic        clr;
    logic [23:0] dig;
    logic [2:0]  cnt;
    logic        kv;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic [1:0] m, input logic [9:0] k, input logic d, input logic c,
                     input logic [23:0] dg, input logic [2:0] cn, input logic v,
                     input logic [3:0] cd);
    vec_t r;
    r.mode = m; r.key = k; r.del = d; r.clr = c;
    r.dig = dg; r.cnt = cn; r.kv = v; r.code = cd;
    vecs.push_back(r);
  endtask

  initial begin
    // Left entry: held key 3 gives one event
    add(2'd2, 10'h008, 0, 0, 24'hFFFFF3, 3'd1, 1, 4'd3);
    for (int i = 0; i < 4; i++) add(2'd2, 10'h008, 0, 0, 24'hFFFFF3, 3'd1, 0, 4'd3);
    add(2'd2, 10'h000, 0, 0, 24'hFFFFF3, 3'd1, 0, 4'd3);
    add(2'd2, 10'h000, 0, 1, 24'hFFFFFF, 3'd0, 0, 4'd3);
    // Left entry 1,2,3 then backspace
    add(2'd2, 10'h002, 0, 0, 24'hFFFFF1, 3'd1, 1, 4'd1);
    add(2'd2, 10'h000, 0, 0, 24'hFFFFF1, 3'd1, 0, 4'd1);
    add(2'd2, 10'h004, 0, 0, 24'hFFFF12, 3'd2, 1, 4'd2);
    add(2'd2, 10'h000, 0, 0, 24'hFFFF12, 3'd2, 0, 4'd2);
    add(2'd2, 10'h008, 0, 0, 24'hFFF123, 3'd3, 1, 4'd3);
    add(2'd2, 10'h000, 0, 0, 24'hFFF123, 3'd3, 0, 4'd3);
    add(2'd2, 10'h000, 1, 0, 24'hFFFF12, 3'd2, 0, 4'd3);
    add(2'd2, 10'h000, 0, 0, 24'hFFFF12, 3'd2, 0, 4'd3);
    // del and press together: del wins, press consumed
    add(2'd2, 10'h001, 1, 0, 24'hFFFFF1, 3'd1, 0, 4'd3);
    add(2'd2, 10'h001, 0, 0, 24'hFFFFF1, 3'd1, 0, 4'd3);
    add(2'd2, 10'h000, 0, 0, 24'hFFFFF1, 3'd1, 0, 4'd3);
    // Right entry 7, 9, then 2+8 together
    add(2'd1, 10'h000, 0, 1, 24'hFFFFFF, 3'd0, 0, 4'd3);
    add(2'd1, 10'h080, 0, 0, 24'h7FFFFF, 3'd1, 1, 4'd7);
    add(2'd1, 10'h000, 0, 0, 24'h7FFFFF, 3'd1, 0, 4'd7);
    add(2'd1, 10'h200, 0, 0, 24'h97FFFF, 3'd2, 1, 4'd9);
    add(2'd1, 10'h000, 0, 0, 24'h97FFFF, 3'd2, 0, 4'd9);
    add(2'd1, 10'h104, 0, 0, 24'h897FFF, 3'd3, 1, 4'd8);
    add(2'd1, 10'h000, 0, 0, 24'h897FFF, 3'd3, 0, 4'd8);
    add(2'd1, 10'h000, 1, 0, 24'h97FFFF, 3'd2, 0, 4'd8);
    // Lock ignores presses and del; clr still works
    add(2'd0, 10'h010, 0, 0, 24'h97FFFF, 3'd2, 0, 4'd8);
    add(2'd0, 10'h000, 1, 0, 24'h97FFFF, 3'd2, 0, 4'd8);
    add(2'd0, 10'h000, 0, 0, 24'h97FFFF, 3'd2, 0, 4'd8);
    add(2'd0, 10'h000, 0, 1, 24'hFFFFFF, 3'd0, 0, 4'd8);
    add(2'd2, 10'h000, 1, 0, 24'hFFFFFF, 3'd0, 0, 4'd8);
    // Fill to DEPTH in left entry
    add(2'd2, 10'h002, 0, 0, 24'hFFFFF1, 3'd1, 1, 4'd1);
    add(2'd2, 10'h000, 0, 0, 24'hFFFFF1, 3'd1, 0, 4'd1);
    add(2'd2, 10'h004, 0, 0, 24'hFFFF12, 3'd2, 1, 4'd2);
    add(2'd2, 10'h000, 0, 0, 24'hFFFF12, 3'd2, 0, 4'd2);
    add(2'd2, 10'h008, 0, 0, 24'hFFF123, 3'd3, 1, 4'd3);
    add(2'd2, 10'h000, 0, 0, 24'hFFF123, 3'd3, 0, 4'd3);
    add(2'd2, 10'h010, 0, 0, 24'hFF1234, 3'd4, 1, 4'd4);
    add(2'd2, 10'h000, 0, 0, 24'hFF1234, 3'd4, 0, 4'd4);
    add(2'd2, 10'h020, 0, 0, 24'hF12345, 3'd5, 1, 4'd5);
    add(2'd2, 10'h000, 0, 0, 24'hF12345, 3'd5, 0, 4'd5);
    add(2'd2, 10'h040, 0, 0, 24'h123456, 3'd6, 1, 4'd6);
    add(2'd2, 10'h000, 0, 0, 24'h123456, 3'd6, 0, 4'd6);

    rst = 1'b1; load = 24'h0;
    step(2'd2, 10'h000, 0, 0);
    step(2'd2, 10'h000, 0, 0);
    chk("rst_dig", d0_dig, 24'hFFFFFF);
    chk("rst_cnt", d0_cnt, 3'd0);
    chk("rst_empty", d0_empty, 1'b1);
    chk("rst_full", d0_full, 1'b0);
    chk("rst_code", d0_code, 4'd0);
    chk("rst_kv", d0_kv, 1'b0);
    chk("rst_ovf", d0_ovf, 1'b0);
    rst = 1'b0;
    step(2'd2, 10'h000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].kv) exp_q.push_back(vecs[i].code);
      step(vecs[i].mode, vecs[i].key, vecs[i].del, vecs[i].clr);
      chk($sformatf("v%0d_dig", i), d0_dig, vecs[i].dig);
      chk($sformatf("v%0d_cnt", i), d0_cnt, vecs[i].cnt);
      chk($sformatf("v%0d_kv", i), d0_kv, vecs[i].kv);
      chk($sformatf("v%0d_code", i), d0_code, vecs[i].code);
      chk($sformatf("v%0d_ovf", i), d0_ovf, 1'b0);
      chk($sformatf("v%0d_full", i), d0_full, vecs[i].cnt == 3'd6);
      chk($sformatf("v%0d_empty", i), d0_empty, vecs[i].cnt == 3'd0);
    end

    // Press 5 while full: drop on dut0, shift on dut1
    step(2'd2, 10'h020, 0, 0);
    chk("ovf0_dig", d0_dig, 24'h123456);
    chk("ovf0_cnt", d0_cnt, 3'd6);
    chk("ovf0_kv", d0_kv, 1'b0);
    chk("ovf0_ovf", d0_ovf, 1'b1);
    chk("ovf0_full", d0_full, 1'b1);
    chk("ovf1_dig", d1_dig, 24'h234565);
    chk("ovf1_cnt", d1_cnt, 3'd6);
    chk("ovf1_kv", d1_kv, 1'b1);
    chk("ovf1_ovf", d1_ovf, 1'b1);
    chk("ovf1_code", d1_code, 4'd5);
    step(2'd2, 10'h000, 0, 0);
    chk("ovf0_pulse", d0_ovf, 1'b0);
    chk("ovf1_pulse", d1_ovf, 1'b0);
    chk("ovf1_kv_pulse", d1_kv, 1'b0);

    // Parallel load ignores the simultaneous press
    load = 24'h987654;
    step(2'd3, 10'h001, 0, 0);
    chk("load_dig", d0_dig, 24'h987654);
    chk("load_cnt", d0_cnt, 3'd6);
    chk("load_full", d0_full, 1'b1);
    chk("load_kv", d0_kv, 1'b0);
    chk("load1_dig", d1_dig, 24'h987654);
    step(2'd3, 10'h000, 0, 1);
    chk("clr_over_load_dig", d0_dig, 24'hFFFFFF);
    chk("clr_over_load_empty", d0_empty, 1'b1);

    // Reset while key 4 held; held key must not be captured afterwards
    step(2'd2, 10'h010, 0, 0);
    exp_q.push_back(4'd4);
    rst = 1'b1;
    step(2'd2, 10'h010, 0, 0);
    step(2'd2, 10'h010, 0, 0);
    chk("rstkey_cnt", d0_cnt, 3'd0);
    chk("rstkey_code", d0_code, 4'd0);
    rst = 1'b0;
    exp_q.delete();
    step(2'd2, 10'h010, 0, 0);
    chk("held_cnt_a", d0_cnt, 3'd0);
    chk("held_kv_a", d0_kv, 1'b0);
    step(2'd2, 10'h010, 0, 0);
    chk("held_cnt_b", d0_cnt, 3'd0);
    step(2'd2, 10'h000, 0, 0);
    exp_q.push_back(4'd4);
    step(2'd2, 10'h010, 0, 0);
    chk("repress_dig", d0_dig, 24'hFFFFF4);
    chk("repress_cnt", d0_cnt, 3'd1);
    chk("repress_kv", d0_kv, 1'b1);
    chk("repress_code", d0_code, 4'd4);
    step(2'd2, 10'h000, 0, 0);
    step(2'd2, 10'h000, 0, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
